// File: rtl/dds_freq_calc_seq.sv
// Sequential DDS output-frequency calculator: f = FSW*F_CLK/2^ACC_W, optional rounding, clamped to OUT_W bits.
// Shift-add multiply over FSW_W cycles, then one normalise cycle; result and done appear FSW_W+2 cycles after start.
module dds_freq_calc_seq #(
  parameter int FSW_W = 8,
  parameter int ACC_W = 8,
  parameter int F_CLK = 10000,
  parameter int OUT_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [FSW_W-1:0] FSW,
  input  logic             round_en,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] frequency_calculated,
  output logic             sat
);

  // F_CLK < 2^clog2(F_CLK+1), so the full product always fits in PW bits.
  localparam int PW = FSW_W + $clog2(F_CLK + 1);
  localparam int QW = PW + 1;
  localparam int MW = (QW > OUT_W) ? QW : OUT_W;
  localparam int CW = $clog2(FSW_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [FSW_W-1:0] fsw_sh;
  logic             rnd;
  logic [PW-1:0]    product;
  logic [PW-1:0]    mcand;
  logic [CW-1:0]    step;
  logic             last_step;

  logic [QW-1:0]    half;
  logic [QW-1:0]    sum;
  logic [QW-1:0]    q;
  logic [MW-1:0]    q_ext;
  logic [MW-1:0]    q_lim;
  logic             q_over;

  assign last_step = (step == CW'(FSW_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     if (last_step) state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Rounding adds half an LSB of the result before the shift; one spare bit absorbs the carry.
  always_comb begin
    half   = rnd ? (QW'(1) << (ACC_W - 1)) : '0;
    sum    = {1'b0, product} + half;
    q      = sum >> ACC_W;
    q_ext  = MW'(q);
    q_lim  = MW'({OUT_W{1'b1}});
    q_over = (q_ext > q_lim);
  end

  // The multiplicand register holds F_CLK << i, so each step only needs a one-bit shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsw_sh               <= '0;
      rnd                  <= 1'b0;
      product              <= '0;
      mcand                <= '0;
      step                 <= '0;
      done                 <= 1'b0;
      frequency_calculated <= '0;
      sat                  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            fsw_sh  <= FSW;
            rnd     <= round_en;
            product <= '0;
            mcand   <= PW'(F_CLK);
            step    <= '0;
          end
        end
        MUL: begin
          if (fsw_sh[0]) product <= product + mcand;
          mcand  <= mcand << 1;
          fsw_sh <= fsw_sh >> 1;
          step   <= step + CW'(1);
        end
        NORM: begin
          frequency_calculated <= q_over ? {OUT_W{1'b1}} : q_ext[OUT_W-1:0];
          sat                  <= q_over;
          done                 <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_freq_calc_seq.sv
// Bench for dds_freq_calc_seq at default parameters: vector table, corner sequences, random vs arithmetic model.
module tb_dds_freq_calc_seq;

  localparam int FSW_W = 8;
  localparam int ACC_W = 8;
  localparam int F_CLK = 10000;
  localparam int OUT_W = 13;
  localparam int LAT   = FSW_W + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [FSW_W-1:0]  FSW;
  logic              round_en;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  freq;
  logic              sat;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dds_freq_calc_seq #(
    .FSW_W(FSW_W), .ACC_W(ACC_W), .F_CLK(F_CLK), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .FSW(FSW), .round_en(round_en),
    .busy(busy), .done(done), .frequency_calculated(freq), .sat(sat)
  );

  typedef struct {
    logic [FSW_W-1:0] fsw;
    logic             rnd;
    logic [OUT_W-1:0] freq;
    logic             sat;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic on the full product, then clamp.
  function automatic void model(input int f, input bit r, output logic [OUT_W-1:0] q, output logic s);
    longint p;
    p = longint'(f) * F_CLK + (r ? (longint'(1) << (ACC_W - 1)) : 0);
    p = p >> ACC_W;
    if (p > (longint'(1) << OUT_W) - 1) begin
      q = '1;
      s = 1'b1;
    end else begin
      q = OUT_W'(p);
      s = 1'b0;
    end
  endfunction

  // mode 0: quiet inputs; 1: random FSW/round_en/start while busy; 2: FSW forced to 255 after capture
  task automatic run_calc(input logic [FSW_W-1:0] f, input logic r, input int mode,
                          input logic [OUT_W-1:0] ef, input logic es, input string name);
    int lat;
    int bc;
    @(negedge clk);
    FSW = f; round_en = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bc  = 0;
    for (int c = 1; c <= 4 * LAT; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (busy) bc++;
      if (mode == 1) begin
        FSW = FSW_W'($urandom);
        round_en = 1'($urandom);
        start = 1'($urandom);
      end else if (mode == 2) begin
        FSW = 8'd255;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, " latency"}, lat, LAT);
    chk({name, " busy_cycles"}, bc, LAT - 1);
    chk({name, " freq"}, 32'(freq), 32'(ef));
    chk({name, " sat"}, 32'(sat), 32'(es));
    chk({name, " busy_at_done"}, 32'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    int first_d;
    int last_d;
    logic [OUT_W-1:0] ef;
    logic es;
    logic [FSW_W-1:0] rf;
    logic rr;

    tbl[0]  = '{8'd128, 1'b0, 13'd5000, 1'b0};
    tbl[1]  = '{8'd13,  1'b0, 13'd507,  1'b0};
    tbl[2]  = '{8'd13,  1'b1, 13'd508,  1'b0};
    tbl[3]  = '{8'd1,   1'b0, 13'd39,   1'b0};
    tbl[4]  = '{8'd1,   1'b1, 13'd39,   1'b0};
    tbl[5]  = '{8'd255, 1'b1, 13'd8191, 1'b1};
    tbl[6]  = '{8'd127, 1'b0, 13'd4960, 1'b0};
    tbl[7]  = '{8'd255, 1'b0, 13'd8191, 1'b1};
    tbl[8]  = '{8'd0,   1'b1, 13'd0,    1'b0};
    tbl[9]  = '{8'd8,   1'b0, 13'd312,  1'b0};
    tbl[10] = '{8'd8,   1'b1, 13'd313,  1'b0};
    tbl[11] = '{8'd209, 1'b1, 13'd8164, 1'b0};
    tbl[12] = '{8'd210, 1'b0, 13'd8191, 1'b1};
    tbl[13] = '{8'd64,  1'b0, 13'd2500, 1'b0};
    tbl[14] = '{8'd2,   1'b0, 13'd78,   1'b0};
    tbl[15] = '{8'd0,   1'b0, 13'd0,    1'b0};

    rst = 1'b1; start = 1'b0; FSW = '0; round_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset freq", 32'(freq), 0);
    chk("reset sat", 32'(sat), 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      run_calc(tbl[i].fsw, tbl[i].rnd, 1, tbl[i].freq, tbl[i].sat, $sformatf("vec%0d", i));

    run_calc(8'd128, 1'b0, 2, 13'd5000, 1'b0, "fsw_change");

    // idle hold: outputs unchanged with start low
    repeat (5) @(negedge clk);
    chk("idle_hold freq", 32'(freq), 5000);
    chk("idle_hold done", 32'(done), 0);

    // abort mid-calculation
    @(negedge clk);
    FSW = 8'd200; round_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy_before", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 3 * LAT; c++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("abort done_count", dcnt, 0);
    chk("abort freq", 32'(freq), 0);
    chk("abort sat", 32'(sat), 0);
    chk("abort busy", 32'(busy), 0);
    run_calc(8'd2, 1'b0, 0, 13'd78, 1'b0, "after_abort");

    // start coinciding with reset is dropped
    run_calc(8'd100, 1'b0, 0, 13'd3906, 1'b0, "pre_rst_start");
    @(negedge clk);
    rst = 1'b1; start = 1'b1; FSW = 8'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start busy", 32'(busy), 0);
    dcnt = 0;
    for (int c = 0; c < 2 * LAT; c++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("rst_start done_count", dcnt, 0);
    chk("rst_start freq", 32'(freq), 0);

    // start held for 30 cycles: accepted only in idle, including the done cycle
    dcnt = 0; first_d = -1; last_d = -1;
    FSW = 8'd64; round_en = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (done) begin
        dcnt++;
        if (first_d < 0) first_d = i;
        last_d = i;
        chk($sformatf("burst freq@%0d", i), 32'(freq), 2500);
      end
      start = (i < 30);
      @(negedge clk);
    end
    start = 1'b0;
    chk("burst done_count", dcnt, 3);
    chk("burst first_done", first_d, LAT);
    chk("burst last_done", last_d, 3 * LAT);

    for (int i = 0; i < 25; i++) begin
      rf = FSW_W'($urandom_range(0, 255));
      rr = 1'($urandom_range(0, 1));
      model(int'(rf), rr, ef, es);
      run_calc(rf, rr, 1, ef, es, $sformatf("rand%0d fsw=%0d rnd=%0d", i, rf, rr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dds_freq_calc_seq.md
DDS_FREQ_CALC_SEQ -- requirements
Module: dds_freq_calc_seq

Interface
REQ-001 Parameter FSW_W, default 8: width of the frequency step word.
REQ-002 Parameter ACC_W, default 8: phase accumulator width; output = FSW*F_CLK/2^ACC_W.
REQ-003 Parameter F_CLK, default 10000: accumulator scanner clock in Hz, a positive integer constant.
REQ-004 Parameter OUT_W, default 13: width of the frequency result.
REQ-005 The module SHALL have one clock and a synchronous, active-high reset.
REQ-006 Port clk, input, 1: the single clock; all state SHALL change on its rising edge only.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port start, input, 1: request a calculation; sampled only in IDLE.
REQ-009 Port FSW, input, FSW_W: frequency step word; captured together with start.
REQ-010 Port round_en, input, 1: 1 = round half-up; 0 = truncate; captured together with start.
REQ-011 Port busy, output, 1: high while a calculation is in progress.
REQ-012 Port done, output, 1: one-cycle pulse when a new result is valid.
REQ-013 Port frequency_calculated, output, OUT_W: result in Hz; holds its value between completions.
REQ-014 Port sat, output, 1: the last result was clamped; updated together with frequency_calculated.

Function
REQ-015 The FSM SHALL have three states: IDLE, MUL and NORM.
REQ-016 IDLE with start=1 SHALL capture FSW and round_en, clear the product, enter MUL and set busy=1 in the next cycle.
REQ-017 In IDLE with start=0 the module SHALL hold all outputs.
REQ-018 MUL SHALL last exactly FSW_W cycles and perform one shift-add step per cycle.
  - Step: product += F_CLK << i when captured FSW bit i = 1, i = 0..FSW_W-1.
  - No combinational multiplier across the full width SHALL be used.
REQ-019 The product register SHALL be FSW_W + clog2(F_CLK+1) bits wide and SHALL never overflow.
REQ-020 NORM SHALL last 1 cycle and compute q = (product + (round_en ? 2^(ACC_W-1) : 0)) >> ACC_W.
  - Rounding addition SHALL be one bit wider than the product.
REQ-021 Saturation: if q > 2^OUT_W-1, frequency_calculated = 2^OUT_W-1 and sat = 1; otherwise frequency_calculated = q and sat = 0.
REQ-022 Latency: with start sampled in cycle T, frequency_calculated, sat and done=1 SHALL be visible in cycle T+FSW_W+2, with the FSM in IDLE and busy=0.
REQ-023 busy SHALL be 1 exactly in cycles T+1 .. T+FSW_W+1.
REQ-024 start while busy=1 SHALL be ignored: no queuing, no effect on the calculation in progress.
REQ-025 start in the same cycle that done=1 SHALL be accepted as a new request (back-to-back throughput: one result per FSW_W+2 cycles).
REQ-026 Changes on FSW or round_en after capture SHALL NOT affect the calculation in progress.
REQ-027 FSW=0 SHALL produce frequency_calculated=0 and sat=0 with the normal latency.

Reset
REQ-028 While rst=1 at a clock edge: state=IDLE, busy=0, done=0, frequency_calculated=0, sat=0, internal registers cleared.
REQ-029 rst asserted mid-calculation SHALL abort it; no done pulse SHALL follow.
REQ-030 start sampled in the same cycle as rst=1 SHALL be ignored.

Verification (default parameters, latency 10 cycles)
REQ-031 FSW=128, round_en=0, start pulse -> done after 10 cycles; frequency_calculated=5000; sat=0; busy high for 9 cycles.
REQ-032 FSW=13: round_en=0 -> 507; round_en=1 -> 508. FSW=1: 39 in both modes.
REQ-033 FSW=255, round_en=1 -> exact 9960.94 exceeds 8191 -> frequency_calculated=8191, sat=1. Then FSW=127, truncate -> 4960, sat=0.
REQ-034 start pulses every cycle for 30 cycles with FSW=64 -> exactly 3 done pulses, each with 2500; busy never re-triggers mid-calculation.
REQ-035 FSW=200 started, rst pulsed at cycle T+4 -> no done pulse; outputs read 0. A following start with FSW=2 -> 78 after 10 cycles.
REQ-036 FSW changed to 255 in cycle T+1 after start with FSW=128 -> result is still 5000.
